pc_stack: RTL and testbench
===========================

Name: pc_stack

Overview:
- Supplies the return-address and interrupt-return values that the next-PC selector consumes as `stackaddr` and `intPC`.
- Subroutine call pushes PC+1 and return pops it.
- Interrupt entry saves the PC and the carry/zero flags; `reti` exposes them for restore.
- Sits beside the next-PC selector in the core datapath, driven by the control unit.

Parameters:
- DEPTH, 8, number of return-address entries (power of two, ≥2)
- AW, 12, PC/address width in bits

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- push_i  in  1  call: push PC_i+1
- pop_i  in  1  return: pop top entry
- PC_i  in  AW  current PC
- int_i  in  1  interrupt entry strobe
- reti_i  in  1  interrupt return strobe
- carry_i  in  1  current carry flag
- zero_i  in  1  current zero flag
- stackaddr_o  out  AW  top-of-stack return address
- intPC_o  out  AW  saved interrupt PC
- intcarry_o  out  1  saved carry
- intzero_o  out  1  saved zero
- int_active_o  out  1  interrupt in service
- empty_o  out  1  no entries
- full_o  out  1  DEPTH entries held
- overflow_o  out  1  sticky: push attempted when full
- underflow_o  out  1  sticky: pop attempted when empty

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state updates on rising clk_i.
  - rst_i is synchronous, active-high, and overrides all inputs in the same edge.
- Reset values:
  - Depth count 0, so empty_o=1 and full_o=0.
  - stackaddr_o=0, intPC_o=0, intcarry_o=0, intzero_o=0.
  - int_active_o=0, overflow_o=0, underflow_o=0.
- stackaddr_o:
  - Combinational view of the top entry, so the selector uses it in the same cycle pop_i is asserted.
  - Reads 0 when empty.
- Push (push_i=1, pop_i=0, not full):
  - entry[count] <= PC_i+1, modulo 2^AW; PC 0xFFF pushes 0x000.
  - count increments.
  - New top is visible the cycle after the edge.
- Pop (pop_i=1, push_i=0, not empty):
  - count decrements; the entry is not cleared.
- Push and pop in the same cycle:
  - Not empty: top entry is replaced with PC_i+1, count unchanged.
  - Empty: behaves as a plain push.
- Push when full:
  - overflow_o <= 1.
  - Stack contents are handled per the optional feature.
- Pop when empty:
  - underflow_o <= 1.
  - count stays 0.
- Sticky flags clear only on rst_i.
- full_o = (count==DEPTH); empty_o = (count==0). The count is held at log2(DEPTH)+1 bits.
- Interrupt save/restore:
  - int_i with int_active_o=0: intPC_o <= PC_i, intcarry_o <= carry_i, intzero_o <= zero_i, int_active_o <= 1.
  - int_i while int_active_o=1 is ignored; there is no nesting and saved values are untouched.
  - reti_i with int_active_o=1: int_active_o <= 0. Saved values persist until the next accepted int_i.
  - reti_i while inactive is ignored.
  - int_i and reti_i together while active: reti wins, int_active_o <= 0 and saved values are unchanged.
  - int_i and reti_i together while inactive: int is accepted.
- Interrupt logic is independent of the stack; push/pop in the same cycle as int/reti are both honoured.

Optional Feature:
- Macro: PC_STACK_WRAP_EN.
- Defined:
  - Push when full discards the oldest entry. Storage is circular with head/tail pointers.
  - The new value becomes top and count stays at DEPTH.
  - overflow_o is still set.
- Undefined:
  - Push when full is dropped; contents and count are unchanged.
  - Storage is a simple indexed array.

Decomposition:
- Shared package gumnut_pkg holds:
  - PC width constant (AW=12) and typedef pc_t = logic [11:0].
  - Default stack depth constant.
- One sub-module, pc_lifo: entry storage plus count/pointers, push/pop/replace, full/empty and sticky flags, including the wrap variant.
- The interrupt save register and int_active logic stay in pc_stack top.

Test Plan:
- Reset then idle:
  - Stimulus: rst_i high for 1 cycle.
  - Required: all outputs 0 except empty_o=1; stackaddr_o=0x000.
- Call/return nesting:
  - Stimulus: push with PC_i=0x010, then 0x020, then 0x030.
  - Required: stackaddr_o sequence 0x011, 0x021, 0x031.
  - Stimulus: three pops.
  - Required: stackaddr_o reads 0x031, 0x021, 0x011 in the pop cycles; empty_o=1 afterwards and underflow_o=0.
- Boundary:
  - Stimulus: 8 pushes (0x100..0x107).
  - Required: full_o=1.
  - Stimulus: a 9th push with PC_i=0x200.
  - Required without wrap: overflow_o=1, top=0x108, count=8.
  - Required with wrap: top=0x201; after 8 pops the last popped value is 0x102.
- Underflow and wrap-around:
  - Stimulus: pop when empty.
  - Required: underflow_o=1, stackaddr_o=0x000.
  - Stimulus: push with PC_i=0xFFF.
  - Required: top=0x000.
- Simultaneous:
  - Stimulus: with top=0x011, assert push+pop, PC_i=0x050.
  - Required: top=0x051, count unchanged.
  - Stimulus: push+pop while empty.
  - Required: acts as push.
- Interrupt:
  - Stimulus: int_i with PC_i=0x3A5, carry_i=1, zero_i=0.
  - Required: intPC_o=0x3A5, intcarry_o=1, intzero_o=0, int_active_o=1.
  - Stimulus: second int_i with PC_i=0x123.
  - Required: ignored.
  - Stimulus: int_i+reti_i together.
  - Required: int_active_o=0, intPC_o still 0x3A5.
  - Stimulus: rst_i mid-service.
  - Required: all interrupt outputs cleared.

Source files
------------

// File: rtl/gumnut_pkg.sv
// Shared core constants: PC width, PC type and default return-stack depth.
package gumnut_pkg;
  localparam int PC_W        = 12;
  localparam int STACK_DEPTH = 8;
  typedef logic [PC_W-1:0] pc_t;
endpackage

// File: rtl/pc_lifo.sv
// Return-address LIFO with count, full/empty and sticky over/underflow flags.
// PC_STACK_WRAP_EN selects circular storage that discards the oldest entry on push-when-full.
module pc_lifo
  import gumnut_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] count;
  logic [PW-1:0] top_idx;
  logic [PW-1:0] waddr;
  logic          we;
  logic          do_repl, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // push+pop on an empty stack falls through to a plain push
  assign do_repl = push && pop && !empty;
  assign do_push = push && !do_repl;
  assign do_pop  = pop && !push;

`ifdef PC_STACK_WRAP_EN
  // head is the next write slot; the oldest live entry sits at head-count
  logic [PW-1:0] head;

  always_comb begin
    top_idx = head - 1'b1;
    waddr   = do_repl ? top_idx : head;
    we      = !rst && (do_repl || do_push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= '0;
    end else if (do_push) begin
      head <= head + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (do_pop && !empty) begin
      head  <= head - 1'b1;
      count <= count - 1'b1;
    end
  end
`else
  always_comb begin
    top_idx = PW'(count - 1'b1);
    waddr   = do_repl ? top_idx : PW'(count);
    we      = !rst && (do_repl || (do_push && !full));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (do_push && !full) begin
      count <= count + 1'b1;
    end else if (do_pop && !empty) begin
      count <= count - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push && full) overflow <= 1'b1;
      if (do_pop && empty) underflow <= 1'b1;
    end
  end

  assign top = empty ? '0 : mem[top_idx];
endmodule

// File: rtl/pc_stack.sv
// Return-address stack plus single-level interrupt PC/flag save for the next-PC selector.
// Build option PC_STACK_WRAP_EN: push-when-full overwrites the oldest return address.
module pc_stack
  import gumnut_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = PC_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] PC_i,
  input  logic          int_i,
  input  logic          reti_i,
  input  logic          carry_i,
  input  logic          zero_i,
  output logic [AW-1:0] stackaddr_o,
  output logic [AW-1:0] intPC_o,
  output logic          intcarry_o,
  output logic          intzero_o,
  output logic          int_active_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          underflow_o
);
  logic [AW-1:0] ret_pc;

  assign ret_pc = PC_i + 1'b1;

  pc_lifo #(.DEPTH(DEPTH), .AW(AW)) u_lifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push_i),
    .pop       (pop_i),
    .din       (ret_pc),
    .top       (stackaddr_o),
    .empty     (empty_o),
    .full      (full_o),
    .overflow  (overflow_o),
    .underflow (underflow_o)
  );

  // No nesting: reti takes priority, and a new int is only taken when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      intPC_o      <= '0;
      intcarry_o   <= 1'b0;
      intzero_o    <= 1'b0;
      int_active_o <= 1'b0;
    end else if (int_active_o) begin
      if (reti_i) int_active_o <= 1'b0;
    end else if (int_i) begin
      intPC_o      <= PC_i;
      intcarry_o   <= carry_i;
      intzero_o    <= zero_i;
      int_active_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed plan steps, then random traffic vs a queue model.
module tb_pc_stack;
  import gumnut_pkg::*;
  localparam int DEPTH = STACK_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0, push = 1'b0, pop = 1'b0, intr = 1'b0, reti = 1'b0;
  logic carry = 1'b0, zero = 1'b0;
  pc_t  pc = '0;
  pc_t  stackaddr, int_pc;
  logic int_carry, int_zero, int_active, empty, full, overflow, underflow;

  always #5 clk = ~clk;

  pc_stack dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .pop_i(pop), .PC_i(pc),
    .int_i(intr), .reti_i(reti), .carry_i(carry), .zero_i(zero),
    .stackaddr_o(stackaddr), .intPC_o(int_pc), .intcarry_o(int_carry),
    .intzero_o(int_zero), .int_active_o(int_active), .empty_o(empty),
    .full_o(full), .overflow_o(overflow), .underflow_o(underflow)
  );

  int checks = 0, errors = 0;

  // reference model: queue back is top of stack
  pc_t q[$];
  bit  m_ovf, m_unf, m_act, m_c, m_z;
  pc_t m_ipc;
  pc_t pre_top;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pc_t m_top();
    return (q.size() == 0) ? pc_t'(0) : q[q.size()-1];
  endfunction

  task automatic m_update(input bit p, po, input pc_t a, input bit i, r, c, z, rs);
    pc_t ret;
    ret = a + 12'd1;
    if (rs) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_act = 0; m_c = 0; m_z = 0; m_ipc = '0;
      return;
    end
    if (p && po && q.size() > 0) q[q.size()-1] = ret;
    else if (p) begin
      if (q.size() < DEPTH) q.push_back(ret);
      else begin
        m_ovf = 1;
`ifdef PC_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(ret);
`endif
      end
    end else if (po) begin
      if (q.size() > 0) void'(q.pop_back());
      else m_unf = 1;
    end
    if (m_act) begin
      if (r) m_act = 0;
    end else if (i) begin
      m_act = 1; m_ipc = a; m_c = c; m_z = z;
    end
  endtask

  task automatic check_all();
    chk("top", stackaddr, m_top());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("int_pc", int_pc, m_ipc);
    chk("int_carry", int_carry, m_c);
    chk("int_zero", int_zero, m_z);
    chk("int_active", int_active, m_act);
  endtask

  task automatic step(input bit p, po, input pc_t a, input bit i, r, c, z, rs);
    push = p; pop = po; pc = a; intr = i; reti = r; carry = c; zero = z; rst = rs;
    #1;
    pre_top = stackaddr;
    if (!rs) chk("pre_edge_top", stackaddr, m_top());
    @(posedge clk);
    m_update(p, po, a, i, r, c, z, rs);
    #1;
    check_all();
  endtask

  initial begin
    // reset then idle
    step(0, 0, 12'h000, 0, 0, 0, 0, 1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_top", stackaddr, 12'h000);
    chk("rst_active", int_active, 1'b0);
    step(0, 0, 12'h000, 0, 0, 0, 0, 0);

    // call/return nesting
    step(1, 0, 12'h010, 0, 0, 0, 0, 0); chk("call1", stackaddr, 12'h011);
    step(1, 0, 12'h020, 0, 0, 0, 0, 0); chk("call2", stackaddr, 12'h021);
    step(1, 0, 12'h030, 0, 0, 0, 0, 0); chk("call3", stackaddr, 12'h031);
    step(0, 1, 12'h000, 0, 0, 0, 0, 0); chk("ret1", pre_top, 12'h031);
    step(0, 1, 12'h000, 0, 0, 0, 0, 0); chk("ret2", pre_top, 12'h021);
    step(0, 1, 12'h000, 0, 0, 0, 0, 0); chk("ret3", pre_top, 12'h011);
    chk("ret_empty", empty, 1'b1);
    chk("ret_no_unf", underflow, 1'b0);

    // fill to full, then overflow
    for (int k = 0; k < 8; k++) step(1, 0, pc_t'(12'h100 + k), 0, 0, 0, 0, 0);
    chk("fill_full", full, 1'b1);
    step(1, 0, 12'h200, 0, 0, 0, 0, 0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_full", full, 1'b1);
`ifdef PC_STACK_WRAP_EN
    chk("ovf_top_wrap", stackaddr, 12'h201);
`else
    chk("ovf_top_drop", stackaddr, 12'h108);
`endif
    for (int k = 0; k < 8; k++) step(0, 1, 12'h000, 0, 0, 0, 0, 0);
`ifdef PC_STACK_WRAP_EN
    chk("last_pop_wrap", pre_top, 12'h102);
`else
    chk("last_pop_drop", pre_top, 12'h101);
`endif
    chk("drain_empty", empty, 1'b1);

    // underflow and PC wrap-around
    step(0, 1, 12'h000, 0, 0, 0, 0, 0);
    chk("unf_flag", underflow, 1'b1);
    chk("unf_top", stackaddr, 12'h000);
    step(1, 0, 12'hFFF, 0, 0, 0, 0, 0);
    chk("pc_wrap_top", stackaddr, 12'h000);
    chk("pc_wrap_nonempty", empty, 1'b0);
    step(0, 1, 12'h000, 0, 0, 0, 0, 0);

    // simultaneous push+pop
    step(1, 0, 12'h010, 0, 0, 0, 0, 0);
    step(1, 1, 12'h050, 0, 0, 0, 0, 0);
    chk("repl_top", stackaddr, 12'h051);
    step(0, 1, 12'h000, 0, 0, 0, 0, 0);
    chk("repl_count", empty, 1'b1);
    step(1, 1, 12'h060, 0, 0, 0, 0, 0);
    chk("pp_empty_top", stackaddr, 12'h061);
    chk("pp_empty_nonempty", empty, 1'b0);

    // interrupt save/restore
    step(0, 0, 12'h000, 0, 0, 0, 0, 1);
    step(0, 0, 12'h3A5, 1, 0, 1, 0, 0);
    chk("int_pc", int_pc, 12'h3A5);
    chk("int_c", int_carry, 1'b1);
    chk("int_z", int_zero, 1'b0);
    chk("int_act", int_active, 1'b1);
    step(0, 0, 12'h123, 1, 0, 0, 1, 0);
    chk("int_nest_pc", int_pc, 12'h3A5);
    chk("int_nest_z", int_zero, 1'b0);
    step(0, 0, 12'h456, 1, 1, 0, 1, 0);
    chk("intreti_act", int_active, 1'b0);
    chk("intreti_pc", int_pc, 12'h3A5);
    step(1, 0, 12'h0AA, 1, 0, 1, 1, 0);
    chk("int2_pc", int_pc, 12'h0AA);
    chk("int2_push", stackaddr, 12'h0AB);
    step(0, 0, 12'h000, 0, 0, 0, 0, 1);
    chk("rst_mid_act", int_active, 1'b0);
    chk("rst_mid_pc", int_pc, 12'h000);
    chk("rst_mid_c", int_carry, 1'b0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, pc_t'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
